crp16_fetch_unit: RTL and testbench
===================================

# crp16_fetch_unit

Parametrised instruction fetch unit for the next-generation crp16 core. Replaces the single-shot, fixed-cadence fetch with a decoupled front end:
- a prefetch FIFO of configurable depth;
- a request/acknowledge/response memory handshake that tolerates wait states;
- a branch redirect that flushes buffered and in-flight instructions.

It sits between instruction memory port A and the decode stage.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of fetch addresses and the PC.
- INSTR_WIDTH, 16, width of an instruction word.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_WIDTH  fetch address; held stable while mem_req is high and mem_ack is low.
- mem_ack  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response data valid; arrives at least 1 cycle after the accepting ack.
- mem_rdata  in  INSTR_WIDTH  response instruction word.
- redirect_valid  in  1  branch taken; flush and refetch from redirect_addr.
- redirect_addr  in  ADDR_WIDTH  branch target.
- instr_valid  out  1  FIFO head holds an instruction.
- instr_ready  in  1  decode consumes the head this cycle.
- instr  out  INSTR_WIDTH  head instruction word.
- instr_next_pc  out  ADDR_WIDTH  head instruction address + 1, modulo 2^ADDR_WIDTH; this is the link/PC-relative base.

## Operation
- Outstanding requests: at most one at any time.
- Request condition: a request is made only when FIFO occupancy + outstanding < DEPTH.
- State machine (state in crp16_fetch_pkg):
  - S_REQ: mem_req = 1.
    - Ack → S_WAIT; fetch_pc += 1.
    - Credit condition false → S_FULL.
  - S_WAIT: awaiting mem_rvalid.
    - On rvalid → S_REQ if credit is available, else S_FULL.
  - S_FULL: mem_req = 0.
    - Returns to S_REQ once a dequeue frees a slot.
- Response handling: a response with the drop flag clear is pushed as {mem_rdata, its address + 1}.
- Drop flag: set by a redirect while a request is outstanding, or in the ack cycle of a request. The matching response is then discarded and the flag cleared.
- Redirect, effective next cycle:
  - FIFO emptied.
  - fetch_pc = redirect_addr.
  - An unacknowledged request is withdrawn and reissued at redirect_addr.
  - State → S_WAIT if a dropped response is pending, else S_REQ.
- Redirect and dequeue in the same cycle: the consumer's handshake completes first, then the flush.
- Redirect and mem_rvalid in the same cycle: the response is discarded.
- Redirect has priority over push and over ack bookkeeping; an acked request still counts as outstanding.
- PC increment and the instr_next_pc addition wrap modulo 2^ADDR_WIDTH; no carry-out is reported.
- Simultaneous push and pop when full: impossible by the credit rule. When empty, the push is visible the following cycle; there is no bypass.

## Timing
- Reset values: mem_req 0, mem_addr RESET_PC, instr_valid 0, instr 0, instr_next_pc 0, FIFO empty, drop flag 0, state S_REQ.
- First mem_req: asserted in the first cycle after reset deasserts.
- Latency: rvalid in cycle N → instr_valid at cycle N+1.
- Redirect in cycle N:
  - mem_addr = target and mem_req = 1 at cycle N+1, provided nothing is outstanding.
  - instr_valid = 0 from N+1 until the first new response is pushed.
- Throughput with a zero-wait memory (ack same cycle, rvalid the next cycle): one instruction every 2 cycles.
- Reset mid-operation: all in-flight state is abandoned. A late mem_rvalid arriving after reset, before any new ack, is ignored.

## Structure
- crp16_fetch_pkg holds:
  - the state enum (S_REQ, S_WAIT, S_FULL);
  - the FIFO entry struct {instr, next_pc};
  - the occupancy-count width function, clog2(DEPTH)+1.
- Sub-module crp16_sync_fifo (parametrised width and depth; push, pop and flush; count output) holds the entries. The fetch unit owns the FSM, PC, drop flag and credit logic.

## Test plan
- Reset release, memory with ack same cycle, rvalid +1, and instr_ready held 1:
  - first mem_addr is 0x0000;
  - instr_next_pc sequence on the output is 0x0001, 0x0002, 0x0003…;
  - one instruction every 2 cycles.
- instr_ready held 0, DEPTH=4:
  - exactly 4 acks occur, then mem_req stays 0 (S_FULL);
  - one dequeue produces one new request next cycle.
- mem_ack delayed 3 cycles:
  - mem_addr is constant 0x0005 across the wait;
  - fetch_pc increments only on ack.
- Redirect to 0x1234 while a response is outstanding:
  - that response is dropped and the FIFO is flushed;
  - next mem_addr is 0x1234;
  - the first valid instr has instr_next_pc 0x1235.
- Redirect coincident with mem_rvalid and instr_ready: the head is consumed, the response is discarded, and instr_valid is 0 at the next cycle.
- fetch_pc at 0xFFFF: the next request addresses 0x0000; that instruction's instr_next_pc is 0x0000.

Source files
------------

// File: rtl/crp16_fetch_pkg.sv
// Shared types for the crp16 fetch front end: FSM states, prefetch entry
// layout and the FIFO occupancy-count width.
package crp16_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL
    } fetch_state_t;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 16;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  next_pc;
    } fetch_entry_t;

    // Count must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/crp16_sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module crp16_sync_fifo
    import crp16_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Flush discards everything, including a pop or push in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/crp16_fetch_unit.sv
// Decoupled instruction fetch: one outstanding memory request, credit-based
// prefetch into a FIFO, and redirect flush with in-flight response dropping.
module crp16_fetch_unit
    import crp16_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic                   mem_rvalid,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_next_pc
);

    localparam int CW = cnt_width(DEPTH);
    localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

    fetch_state_t           state;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  pend_pc;
    logic [ADDR_WIDTH-1:0]  rsp_next_pc;
    logic                   pend;
    logic                   drop;
    logic [CW-1:0]          count;
    logic [EW-1:0]          head;
    logic                   ack_now, rsp_now, push, pop, pend_n;
    logic                   credit_now, credit_next;
    int                     occ_next;

    assign mem_req     = (state == S_REQ) && !reset;
    assign mem_addr    = fetch_pc;
    assign ack_now     = mem_req && mem_ack;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign rsp_now     = mem_rvalid && pend;
    assign push        = rsp_now && !drop && !redirect_valid;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign pend_n      = ack_now || (pend && !rsp_now);
    assign rsp_next_pc = pend_pc + 1'b1;

    assign occ_next    = int'(count) + int'(push) - int'(pop);
    assign credit_now  = (int'(count) + int'(pend)) < DEPTH;
    assign credit_next = (occ_next + int'(pend_n)) < DEPTH;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            pend     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            pend <= pend_n;
            if (ack_now) pend_pc <= fetch_pc;
            // An acked request stays outstanding across a redirect; its data is dropped.
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
                drop     <= pend_n;
                state    <= pend_n ? S_WAIT : S_REQ;
            end else begin
                if (rsp_now) drop <= 1'b0;
                case (state)
                    S_REQ: begin
                        if (ack_now) begin
                            fetch_pc <= fetch_pc + 1'b1;
                            state    <= S_WAIT;
                        end else if (!credit_now) begin
                            state <= S_FULL;
                        end
                    end
                    S_WAIT:  if (rsp_now) state <= credit_next ? S_REQ : S_FULL;
                    S_FULL:  if (credit_next) state <= S_REQ;
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    crp16_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({mem_rdata, rsp_next_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign instr         = instr_valid ? head[EW-1 -: INSTR_WIDTH] : '0;
    assign instr_next_pc = instr_valid ? head[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_crp16_fetch_unit.sv
// Bench for crp16_fetch_unit: memory model with programmable ack/response
// delay, scoreboard queue of expected FIFO entries, redirect vector table.
module tb_crp16_fetch_unit;
    import crp16_fetch_pkg::*;

    logic        clock, reset;
    logic        mem_req, mem_ack, mem_rvalid;
    logic [15:0] mem_addr, mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        instr_valid, instr_ready;
    logic [15:0] instr, instr_next_pc;

    crp16_fetch_unit #(.ADDR_WIDTH(16), .INSTR_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_next_pc(instr_next_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0, checks = 0, cyc = 0;
    int ack_delay = 0, rsp_delay = 1, wait_cnt = 0, rsp_wait = 0;
    int n_acks = 0, n_pops = 0, last_pop_cyc = -1;
    bit rdy = 0, redir = 0, stray = 0, inf_v = 0, inf_live = 0, chk_gap = 0;
    bit prev_req = 0, prev_ack = 0, prev_redir = 0, last_req = 0, last_valid = 0;
    logic [15:0] redir_addr = '0, inf_addr = '0, exp_pc = '0, prev_addr = '0;
    logic [15:0] last_ack_addr = '0, last_npc = '0;
    fetch_entry_t q[$];
    logic [15:0] popped[$];

    typedef struct {
        logic [15:0] target;
        logic [15:0] exp_addr;
        logic [15:0] exp_npc;
        logic [15:0] exp_second;
    } redir_vec_t;
    redir_vec_t vecs[4];

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        fetch_entry_t e;
        bit deliver, ack;
        @(negedge clock);
        cyc++;
        deliver = inf_v && (rsp_wait == 1);
        if (inf_v && !deliver) rsp_wait--;
        mem_rvalid = deliver || stray;
        mem_rdata  = deliver ? mdata(inf_addr) : (stray ? 16'hDEAD : 16'h0000);
        stray = 0;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_addr  = redir_addr;
        ack = 0;
        if (mem_req) begin
            chk("one_outstanding", inf_v, 0);
            if (prev_req && !prev_ack && !prev_redir) chk("addr_hold", mem_addr, prev_addr);
            if (wait_cnt >= ack_delay) begin
                ack = 1;
                wait_cnt = 0;
                chk("ack_addr", mem_addr, exp_pc);
                exp_pc = exp_pc + 16'd1;
                n_acks++;
                last_ack_addr = mem_addr;
            end else begin
                wait_cnt++;
            end
        end
        mem_ack = ack;
        chk("instr_valid", instr_valid, q.size() != 0);
        if (instr_valid && rdy && q.size() != 0) begin
            e = q.pop_front();
            chk("instr", instr, e.instr);
            chk("instr_next_pc", instr_next_pc, e.next_pc);
            popped.push_back(instr_next_pc);
            n_pops++;
            if (chk_gap && last_pop_cyc >= 0) chk("pop_gap", cyc - last_pop_cyc, 2);
            last_pop_cyc = cyc;
        end
        if (redir) begin
            q.delete();
            inf_live = 0;
            wait_cnt = 0;
            exp_pc = redir_addr;
        end
        if (deliver) begin
            if (inf_live) q.push_back('{instr: mdata(inf_addr), next_pc: 16'(inf_addr + 16'd1)});
            inf_v = 0;
        end
        if (ack) begin
            inf_v = 1;
            inf_live = !redir;
            inf_addr = mem_addr;
            rsp_wait = rsp_delay;
        end
        prev_req = mem_req; prev_ack = ack; prev_redir = redir; prev_addr = mem_addr;
        last_req = mem_req; last_valid = instr_valid; last_npc = instr_next_pc;
        redir = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; mem_ack = 0; mem_rvalid = 0; redirect_valid = 0; instr_ready = 0;
        q.delete(); inf_v = 0; wait_cnt = 0; exp_pc = 16'h0000; redir = 0; stray = 0;
        prev_req = 0; prev_ack = 0; prev_redir = 0; last_pop_cyc = -1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_instr_next_pc", instr_next_pc, 16'h0000);
        @(posedge clock);
        #1 reset = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int base, p;
        vecs[0] = '{16'h1234, 16'h1234, 16'h1235, 16'h1235};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0001, 16'h0001};
        reset = 1; mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
        redirect_valid = 0; redirect_addr = 0; instr_ready = 0;

        // Zero-wait memory, consumer always ready.
        do_reset();
        rdy = 1; ack_delay = 0; rsp_delay = 1;
        tick();
        chk("first_req", last_req, 1);
        chk("first_addr", prev_addr, 16'h0000);
        chk_gap = 1;
        repeat (20) tick();
        chk_gap = 0;
        chk("stream_pops", n_pops, 10);
        chk("npc_0", popped[0], 16'h0001);
        chk("npc_1", popped[1], 16'h0002);
        chk("npc_2", popped[2], 16'h0003);

        // Consumer stalled: exactly DEPTH acks, then a single pop frees one request.
        do_reset();
        rdy = 0; n_acks = 0;
        repeat (20) tick();
        chk("full_acks", n_acks, 4);
        chk("full_no_req", last_req, 0);
        rdy = 1; tick();
        chk("pop_cycle_no_req", last_req, 0);
        rdy = 0; tick();
        chk("req_after_pop", last_req, 1);
        chk("acks_after_pop", n_acks, 5);
        rdy = 1;
        repeat (12) tick();

        // Ack delayed by 3 cycles on the sixth request.
        do_reset();
        rdy = 1; n_acks = 0;
        for (int i = 0; i < 30 && n_acks < 5; i++) tick();
        chk("five_acks", n_acks, 5);
        ack_delay = 3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_req) break;
        end
        chk("wait_req", last_req, 1);
        chk("wait_addr", prev_addr, 16'h0005);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_req_held", last_req, 1);
            chk("wait_addr_held", prev_addr, 16'h0005);
        end
        chk("ack_after_wait", n_acks, 6);
        tick();
        chk("pc_after_ack", prev_addr, 16'h0006);
        ack_delay = 0;
        repeat (6) tick();

        // Redirect vectors, issued while an unacknowledged request is pending.
        for (int v = 0; v < 4; v++) begin
            ack_delay = 5; rdy = 1;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (last_req && !prev_ack) break;
            end
            chk("vec_pre_req", last_req, 1);
            redir = 1; redir_addr = vecs[v].target;
            tick();
            base = n_acks;
            ack_delay = 0;
            tick();
            chk("vec_req", last_req, 1);
            chk("vec_addr", prev_addr, vecs[v].exp_addr);
            for (int i = 0; i < 20; i++) begin
                tick();
                if (last_valid) break;
            end
            chk("vec_valid", last_valid, 1);
            chk("vec_npc", last_npc, vecs[v].exp_npc);
            for (int i = 0; i < 20 && n_acks < base + 2; i++) tick();
            chk("vec_second_addr", last_ack_addr, vecs[v].exp_second);
        end

        // Redirect while a response is outstanding: dropped, FIFO flushed.
        do_reset();
        rdy = 0; ack_delay = 0; rsp_delay = 3;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (q.size() >= 1 && prev_ack) break;
        end
        chk("outst_setup", q.size() >= 1 && inf_v, 1);
        base = n_acks;
        redir = 1; redir_addr = 16'h1234;
        tick();
        tick();
        chk("outst_flush", last_valid, 0);
        chk("outst_wait_drop", last_req, 0);
        rdy = 1; rsp_delay = 1;
        for (int i = 0; i < 20 && n_acks < base + 1; i++) tick();
        chk("outst_next_addr", last_ack_addr, 16'h1234);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_valid) break;
        end
        chk("outst_valid", last_valid, 1);
        chk("outst_npc", last_npc, 16'h1235);
        repeat (6) tick();

        // Redirect coincident with mem_rvalid and a consumed head.
        do_reset();
        rdy = 0; ack_delay = 0; rsp_delay = 1;
        for (int i = 0; i < 40 && !(q.size() >= 2 && inf_v && rsp_wait == 1); i++) tick();
        chk("coinc_setup", q.size() >= 2 && inf_v && rsp_wait == 1, 1);
        p = n_pops;
        rdy = 1; redir = 1; redir_addr = 16'h0040;
        tick();
        chk("coinc_pop", n_pops, p + 1);
        tick();
        chk("coinc_flush", last_valid, 0);
        chk("coinc_req_addr", prev_addr, 16'h0040);
        repeat (8) tick();

        // Reset with a response in flight, then a stale rvalid right after release.
        do_reset();
        rdy = 0; rsp_delay = 2;
        for (int i = 0; i < 10 && !inf_v; i++) tick();
        chk("late_setup", inf_v, 1);
        do_reset();
        stray = 1; ack_delay = 1;
        tick();
        chk("late_req", last_req, 1);
        tick();
        chk("late_ignored", last_valid, 0);
        tick();
        chk("late_ignored2", last_valid, 0);
        rdy = 1; ack_delay = 0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
